// File: rtl/rom_store.sv
// Boot (4 KiB) and character (1 KiB) ROM store fed by the ROM-init decoder.
// Tracks per-region load completeness and a boot checksum; holds the core in reset until the image is good.
module rom_store #(
    parameter int          BOOT_SIZE    = 4096,
    parameter int          CHR_SIZE     = 1024,
    parameter int          SUM_CHECK_EN = 0,
    parameter logic [7:0]  BOOT_SUM_EXP = 8'h00
) (
    input  logic        CLK_SYS,
    input  logic        RESB,
    input  logic        IOCTL_DOWNLOAD,
    input  logic        ROMINIT_SEL_BOOT,
    input  logic        ROMINIT_SEL_CHR,
    input  logic [11:0] ROMINIT_ADDR,
    input  logic [7:0]  ROMINIT_DATA,
    input  logic        ROMINIT_VALID,
    input  logic [11:0] BOOT_A,
    output logic [7:0]  BOOT_DB,
    input  logic [9:0]  CHR_A,
    output logic [7:0]  CHR_DB,
    output logic        ROM_READY,
    output logic        ROM_ERROR,
    output logic [7:0]  BOOT_SUM,
    output logic        CPU_RESB
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_READY,
        S_ERROR
    } state_t;

    localparam logic [12:0] BOOT_CNT_FULL = 13'(BOOT_SIZE);
    localparam logic [12:0] BOOT_CNT_SAT  = 13'(BOOT_SIZE + 1);
    localparam logic [10:0] CHR_CNT_FULL  = 11'(CHR_SIZE);
    localparam logic [10:0] CHR_CNT_SAT   = 11'(CHR_SIZE + 1);

    logic [7:0]  r_boot_mem [0:4095];
    logic [7:0]  r_chr_mem  [0:1023];

    state_t      r_state;
    logic        r_dl_q;
    logic [12:0] r_boot_cnt;
    logic [10:0] r_chr_cnt;
    logic [7:0]  r_boot_sum;
    logic        r_ready;
    logic        r_error;
    logic [7:0]  r_boot_db;
    logic [7:0]  r_chr_db;

    logic        w_start;
    logic        w_done;
    logic        w_wr_boot;
    logic        w_wr_chr;
    logic        w_sum_ok;
    logic        w_pass;

    assign w_start   = IOCTL_DOWNLOAD & ~r_dl_q;
    assign w_done    = ~IOCTL_DOWNLOAD & r_dl_q;
    assign w_wr_boot = ROMINIT_VALID & ROMINIT_SEL_BOOT;
    assign w_wr_chr  = ROMINIT_VALID & ROMINIT_SEL_CHR;
    assign w_sum_ok  = (SUM_CHECK_EN == 0) || (r_boot_sum == BOOT_SUM_EXP);
    assign w_pass    = (r_boot_cnt == BOOT_CNT_FULL) && (r_chr_cnt == CHR_CNT_FULL) && w_sum_ok;

    // Array storage is deliberately not reset so it maps onto block RAM.
    always_ff @(posedge CLK_SYS) begin
        if (w_wr_boot) begin
            r_boot_mem[ROMINIT_ADDR] <= ROMINIT_DATA;
        end
        if (w_wr_chr) begin
            r_chr_mem[ROMINIT_ADDR[9:0]] <= ROMINIT_DATA;
        end
    end

    always_ff @(posedge CLK_SYS) begin
        if (!RESB) begin
            r_boot_db <= '0;
            r_chr_db  <= '0;
        end else begin
            r_boot_db <= r_boot_mem[BOOT_A];
            r_chr_db  <= r_chr_mem[CHR_A];
        end
    end

    always_ff @(posedge CLK_SYS) begin
        if (!RESB) begin
            r_state    <= S_IDLE;
            r_dl_q     <= 1'b0;
            r_boot_cnt <= '0;
            r_chr_cnt  <= '0;
            r_boot_sum <= '0;
            r_ready    <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_dl_q <= IOCTL_DOWNLOAD;

            // A write landing in the start cycle is the first byte of the new image.
            if (w_start) begin
                r_boot_cnt <= w_wr_boot ? 13'd1 : '0;
                r_chr_cnt  <= w_wr_chr ? 11'd1 : '0;
                r_boot_sum <= w_wr_boot ? ROMINIT_DATA : '0;
            end else begin
                if (w_wr_boot) begin
                    r_boot_sum <= r_boot_sum + ROMINIT_DATA;
                    if (r_boot_cnt != BOOT_CNT_SAT) begin
                        r_boot_cnt <= r_boot_cnt + 13'd1;
                    end
                end
                if (w_wr_chr && (r_chr_cnt != CHR_CNT_SAT)) begin
                    r_chr_cnt <= r_chr_cnt + 11'd1;
                end
            end

            if (w_start) begin
                r_state <= S_LOAD;
            end else begin
                case (r_state)
                    S_LOAD:  if (w_done) r_state <= S_CHECK;
                    S_CHECK: r_state <= w_pass ? S_READY : S_ERROR;
                    default: r_state <= r_state;
                endcase
            end

            // Status flags trail the state by one edge and drop on the start edge.
            r_ready <= ~w_start & (r_state == S_READY);
            r_error <= ~w_start & (r_state == S_ERROR);
        end
    end

    assign BOOT_DB   = r_boot_db;
    assign CHR_DB    = r_chr_db;
    assign ROM_READY = r_ready;
    assign ROM_ERROR = r_error;
    assign BOOT_SUM  = r_boot_sum;
    assign CPU_RESB  = r_ready;

endmodule

// File: tb/tb_rom_store.sv
// Directed bench for rom_store: default instance plus a checksum-enforcing instance sharing inputs.
module tb_rom_store;

    logic        CLK_SYS = 1'b0;
    logic        RESB = 1'b0;
    logic        IOCTL_DOWNLOAD = 1'b0;
    logic        ROMINIT_SEL_BOOT = 1'b0;
    logic        ROMINIT_SEL_CHR = 1'b0;
    logic [11:0] ROMINIT_ADDR = '0;
    logic [7:0]  ROMINIT_DATA = '0;
    logic        ROMINIT_VALID = 1'b0;
    logic [11:0] BOOT_A = '0;
    logic [9:0]  CHR_A = '0;

    logic [7:0]  boot_db, chr_db, boot_sum;
    logic        rom_ready, rom_error, cpu_resb;
    logic [7:0]  s_boot_db, s_chr_db, s_boot_sum;
    logic        s_rom_ready, s_rom_error, s_cpu_resb;

    int total = 0;
    int bad = 0;
    logic first_ready;
    logic first_resb;
    logic [7:0] first_sum;

    always #5 CLK_SYS = ~CLK_SYS;

    rom_store u_dut (
        .CLK_SYS(CLK_SYS), .RESB(RESB), .IOCTL_DOWNLOAD(IOCTL_DOWNLOAD),
        .ROMINIT_SEL_BOOT(ROMINIT_SEL_BOOT), .ROMINIT_SEL_CHR(ROMINIT_SEL_CHR),
        .ROMINIT_ADDR(ROMINIT_ADDR), .ROMINIT_DATA(ROMINIT_DATA), .ROMINIT_VALID(ROMINIT_VALID),
        .BOOT_A(BOOT_A), .BOOT_DB(boot_db), .CHR_A(CHR_A), .CHR_DB(chr_db),
        .ROM_READY(rom_ready), .ROM_ERROR(rom_error), .BOOT_SUM(boot_sum), .CPU_RESB(cpu_resb)
    );

    rom_store #(.SUM_CHECK_EN(1), .BOOT_SUM_EXP(8'h00)) u_dut_sum (
        .CLK_SYS(CLK_SYS), .RESB(RESB), .IOCTL_DOWNLOAD(IOCTL_DOWNLOAD),
        .ROMINIT_SEL_BOOT(ROMINIT_SEL_BOOT), .ROMINIT_SEL_CHR(ROMINIT_SEL_CHR),
        .ROMINIT_ADDR(ROMINIT_ADDR), .ROMINIT_DATA(ROMINIT_DATA), .ROMINIT_VALID(ROMINIT_VALID),
        .BOOT_A(BOOT_A), .BOOT_DB(s_boot_db), .CHR_A(CHR_A), .CHR_DB(s_chr_db),
        .ROM_READY(s_rom_ready), .ROM_ERROR(s_rom_error), .BOOT_SUM(s_boot_sum), .CPU_RESB(s_cpu_resb)
    );

    task automatic tick();
        @(posedge CLK_SYS);
        #1;
    endtask

    // kind 0: addr[7:0], 1: ~addr[7:0], 2: constant 0x01; bump address gets 0x02
    function automatic logic [7:0] dfn(input int kind, input int a, input int bump);
        logic [7:0] lo;
        lo = a[7:0];
        if (a == bump) return 8'h02;
        case (kind)
            0: return lo;
            1: return ~lo;
            default: return 8'h01;
        endcase
    endfunction

    task automatic send_boot(input int from, input int n, input int kind, input int bump);
        for (int a = from; a < from + n; a++) begin
            IOCTL_DOWNLOAD   = 1'b1;
            ROMINIT_SEL_BOOT = 1'b1;
            ROMINIT_SEL_CHR  = 1'b0;
            ROMINIT_ADDR     = a[11:0];
            ROMINIT_DATA     = dfn(kind, a, bump);
            ROMINIT_VALID    = 1'b1;
            tick();
            if (a == from) begin
                first_ready = rom_ready;
                first_resb  = cpu_resb;
                first_sum   = boot_sum;
            end
        end
        ROMINIT_VALID = 1'b0;
        ROMINIT_SEL_BOOT = 1'b0;
    endtask

    task automatic send_chr(input int n, input int kind);
        for (int a = 0; a < n; a++) begin
            ROMINIT_SEL_BOOT = 1'b0;
            ROMINIT_SEL_CHR  = 1'b1;
            ROMINIT_ADDR     = a[11:0];
            ROMINIT_DATA     = dfn(kind, a, -1);
            ROMINIT_VALID    = 1'b1;
            tick();
        end
        ROMINIT_VALID   = 1'b0;
        ROMINIT_SEL_CHR = 1'b0;
        tick();
    endtask

    // Drops DOWNLOAD and waits the two edges before the flags may move.
    task automatic end_download();
        IOCTL_DOWNLOAD = 1'b0;
        tick();
        tick();
        total++;
        if (rom_ready !== 1'b0 || rom_error !== 1'b0) begin
            bad++;
            $display("FAIL early_flags got ready=%b error=%b exp ready=0 error=0", rom_ready, rom_error);
        end
        tick();
    endtask

    task automatic test_reset();
        RESB = 1'b0;
        tick();
        tick();
        total++;
        if ({rom_ready, rom_error, cpu_resb} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags got %b exp 000", {rom_ready, rom_error, cpu_resb});
        end
        total++;
        if ({boot_sum, boot_db, chr_db} !== 24'h0) begin
            bad++;
            $display("FAIL reset_data got %h exp 000000", {boot_sum, boot_db, chr_db});
        end
        RESB = 1'b1;
        tick();
    endtask

    task automatic test_full_image();
        send_boot(0, 4096, 0, -1);
        send_chr(1024, 0);
        end_download();
        total++;
        if ({rom_ready, cpu_resb, rom_error} !== 3'b110) begin
            bad++;
            $display("FAIL full_ready got rdy/resb/err=%b exp 110", {rom_ready, cpu_resb, rom_error});
        end
        total++;
        if (boot_sum !== 8'h00) begin
            bad++;
            $display("FAIL full_sum got %h exp 00", boot_sum);
        end
        BOOT_A = 12'h0A5;
        CHR_A  = 10'h3FF;
        tick();
        total++;
        if (boot_db !== 8'hA5) begin
            bad++;
            $display("FAIL full_boot_rd got %h exp a5", boot_db);
        end
        total++;
        if (chr_db !== 8'hFF) begin
            bad++;
            $display("FAIL full_chr_rd got %h exp ff", chr_db);
        end
    endtask

    task automatic test_redownload();
        send_boot(0, 4096, 1, -1);
        total++;
        if ({first_ready, first_resb} !== 2'b00) begin
            bad++;
            $display("FAIL redl_drop got ready/resb=%b exp 00", {first_ready, first_resb});
        end
        total++;
        if (first_sum !== 8'hFF) begin
            bad++;
            $display("FAIL redl_sum_restart got %h exp ff", first_sum);
        end
        send_chr(1024, 1);
        end_download();
        total++;
        if ({rom_ready, cpu_resb} !== 2'b11) begin
            bad++;
            $display("FAIL redl_ready got %b exp 11", {rom_ready, cpu_resb});
        end
        BOOT_A = 12'h0A5;
        CHR_A  = 10'h3FF;
        tick();
        total++;
        if ({boot_db, chr_db} !== 16'h5A00) begin
            bad++;
            $display("FAIL redl_read got %h exp 5a00", {boot_db, chr_db});
        end
    endtask

    task automatic test_short_image();
        send_boot(0, 4095, 0, -1);
        send_chr(1024, 0);
        end_download();
        total++;
        if ({rom_error, rom_ready, cpu_resb} !== 3'b100) begin
            bad++;
            $display("FAIL short_error got err/rdy/resb=%b exp 100", {rom_error, rom_ready, cpu_resb});
        end
    endtask

    task automatic test_checksum();
        send_boot(0, 4096, 2, -1);
        send_chr(1024, 2);
        end_download();
        total++;
        if ({s_rom_ready, s_rom_error, s_boot_sum} !== {2'b10, 8'h00}) begin
            bad++;
            $display("FAIL sum_good got rdy=%b err=%b sum=%h exp 1 0 00", s_rom_ready, s_rom_error, s_boot_sum);
        end
        send_boot(0, 4096, 2, 100);
        send_chr(1024, 2);
        end_download();
        total++;
        if ({s_rom_ready, s_rom_error, s_boot_sum} !== {2'b01, 8'h01}) begin
            bad++;
            $display("FAIL sum_bad got rdy=%b err=%b sum=%h exp 0 1 01", s_rom_ready, s_rom_error, s_boot_sum);
        end
        total++;
        if ({rom_ready, rom_error} !== 2'b10) begin
            bad++;
            $display("FAIL sum_ignored got rdy/err=%b exp 10", {rom_ready, rom_error});
        end
    endtask

    task automatic test_reset_mid_download();
        send_boot(0, 2000, 0, -1);
        RESB = 1'b0;
        tick();
        total++;
        if ({rom_ready, rom_error, boot_sum} !== 10'h0) begin
            bad++;
            $display("FAIL mid_reset got rdy=%b err=%b sum=%h exp 0 0 00", rom_ready, rom_error, boot_sum);
        end
        RESB = 1'b1;
        send_boot(2000, 2096, 0, -1);
        send_chr(1024, 0);
        end_download();
        total++;
        if ({rom_error, rom_ready, cpu_resb} !== 3'b100) begin
            bad++;
            $display("FAIL mid_error got err/rdy/resb=%b exp 100", {rom_error, rom_ready, cpu_resb});
        end
    endtask

    task automatic test_collision();
        BOOT_A           = 12'h010;
        ROMINIT_SEL_BOOT = 1'b1;
        ROMINIT_ADDR     = 12'h010;
        ROMINIT_DATA     = 8'h5A;
        ROMINIT_VALID    = 1'b1;
        tick();
        ROMINIT_VALID    = 1'b0;
        ROMINIT_SEL_BOOT = 1'b0;
        total++;
        if (boot_db !== 8'h10) begin
            bad++;
            $display("FAIL coll_old got %h exp 10", boot_db);
        end
        tick();
        total++;
        if (boot_db !== 8'h5A) begin
            bad++;
            $display("FAIL coll_new got %h exp 5a", boot_db);
        end
    endtask

    initial begin
        test_reset();
        test_full_image();
        test_redownload();
        test_short_image();
        test_checksum();
        test_reset_mid_download();
        test_collision();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
